// File: rtl/imem_stream_loader_if.sv
// Byte-stream input and instruction-memory write port of imem_stream_loader.
// slave  : the loader's view (consumes bytes, drives the memory write port).
// master : the surrounding system's view (byte source and memory).
interface imem_stream_loader_if #(
   parameter int ADDR_W = 8
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_stream_loader.sv
// imem_stream_loader: receives a byte stream (count byte, then hi/lo byte
// pairs) and writes the assembled 16-bit words to consecutive instruction
// memory addresses starting at BASE_ADDR, keeping the core held meanwhile.
// Optional build macro LOADER_CHECKSUM_EN: a trailing XOR checksum byte
// must match the XOR of all preceding bytes of the session, else ERR.
module imem_stream_loader #(
   parameter int ADDR_W    = 8,
   parameter int DEPTH     = 32,
   parameter int BASE_ADDR = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   imem_stream_loader_if.slave bus,
   output logic                cpu_hold,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [ADDR_W:0]     words_loaded
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_COUNT = 3'd1;
   localparam logic [2:0] S_HI    = 3'd2;
   localparam logic [2:0] S_LO    = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_CSUM  = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;
   localparam logic [2:0] S_ERR   = 3'd7;

   // State entered once the last word (or an empty program) has been handled.
`ifdef LOADER_CHECKSUM_EN
   localparam logic [2:0] S_FIN = S_CSUM;
`else
   localparam logic [2:0] S_FIN = S_DONE;
`endif

   logic [2:0]        state_q, state_d;
   logic [7:0]        count_q, count_d;
   logic [7:0]        hi_q, hi_d;
   logic [ADDR_W-1:0] addr_q, addr_d;        // next address to write
   logic [ADDR_W-1:0] waddr_q, waddr_d;      // address presented on the port
   logic [15:0]       wdata_q, wdata_d;      // word presented on the port
   logic [ADDR_W:0]   words_q, words_d;
   logic              busy_q, done_q, err_q, hold_q;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif
   logic              ready;
   logic              xfer;

   // Next-state and datapath decisions for the load session.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      hi_d    = hi_q;
      addr_d  = addr_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      words_d = words_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      ready = (state_q == S_COUNT) || (state_q == S_HI) ||
              (state_q == S_LO)    || (state_q == S_CSUM);
      xfer  = ready && bus.in_valid;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_COUNT;
               words_d = '0;
               addr_d  = ADDR_W'(BASE_ADDR);
`ifdef LOADER_CHECKSUM_EN
               csum_d  = 8'h00;
`endif
            end
         end
         S_COUNT: begin
            if (xfer) begin
               count_d = bus.in_data;
`ifdef LOADER_CHECKSUM_EN
               csum_d  = csum_q ^ bus.in_data;
`endif
               if (bus.in_data == 8'h00)
                  state_d = S_FIN;
               else if (int'(bus.in_data) > (DEPTH - BASE_ADDR))
                  state_d = S_ERR;
               else
                  state_d = S_HI;
            end
         end
         S_HI: begin
            if (xfer) begin
               hi_d    = bus.in_data;
`ifdef LOADER_CHECKSUM_EN
               csum_d  = csum_q ^ bus.in_data;
`endif
               state_d = S_LO;
            end
         end
         S_LO: begin
            if (xfer) begin
               // Port registers change only as the write cycle begins, so
               // they hold the previous write's values until then.
               waddr_d = addr_q;
               wdata_d = {hi_q, bus.in_data};
`ifdef LOADER_CHECKSUM_EN
               csum_d  = csum_q ^ bus.in_data;
`endif
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            addr_d  = addr_q + 1'b1;
            words_d = words_q + 1'b1;
            if (int'(words_q) + 1 == int'(count_q))
               state_d = S_FIN;
            else
               state_d = S_HI;
         end
         S_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
            if (xfer)
               state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Register state, datapath and status; status flags are decoded from the
   // state being entered so they change together with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         count_q <= 8'h00;
         hi_q    <= 8'h00;
         addr_q  <= '0;
         waddr_q <= '0;
         wdata_q <= 16'h0000;
         words_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         hold_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         addr_q  <= addr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         words_q <= words_d;
         busy_q  <= (state_d == S_COUNT) || (state_d == S_HI) || (state_d == S_LO) ||
                    (state_d == S_WRITE) || (state_d == S_CSUM);
         done_q  <= (state_d == S_DONE);
         err_q   <= (state_d == S_ERR);
         // The core stays held after an abort so a partial program never runs.
         hold_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign bus.in_ready   = ready;
   assign bus.imem_we    = (state_q == S_WRITE);
   assign bus.imem_addr  = waddr_q;
   assign bus.imem_wdata = wdata_q;
   assign cpu_hold       = hold_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign err            = err_q;
   assign words_loaded   = words_q;

endmodule
